// File: rtl/uart_resp_pkg.sv
// uart_resp_pkg: shared opcodes, responses, FSM states and counter sizing for the UART register responder
package uart_resp_pkg;
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, EXEC, SEND, WAIT_BUSY, WAIT_IDLE} state_t;
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/uart_resp_regfile.sv
// uart_resp_regfile: byte-wide register file with one synchronous write port, combinational read and flat export
module uart_resp_regfile import uart_resp_pkg::*; #(
  parameter int NUM_REGS = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] addr,
  input  logic [7:0]                  wdata,
  output logic [7:0]                  rdata,
  output logic [NUM_REGS*8-1:0]       regs_flat
);
  logic [7:0] regs [NUM_REGS];
  // registers clear on reset and take wdata at addr when we is high
  always_ff @(posedge clk) begin
    if (reset) regs <= '{default: '0};
    else if (we) regs[addr] <= wdata;
  end
  assign rdata = regs[addr];
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs[g];
  end
endmodule

// File: rtl/uart_reg_responder.sv
// uart_reg_responder: parses UART read/write commands into a register file and sends one response byte each
module uart_reg_responder import uart_resp_pkg::*; #(
  parameter int NUM_REGS = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  timeout_pulse,
  output logic                  rx_drop
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  state_t state;
  logic is_wr, we, addr_ok, waiting, expire, busy_phase;
  logic [7:0] addr, data, rdata;
  logic [CW-1:0] cnt;
  assign addr_ok = {1'b0, addr} < 9'(NUM_REGS);
  assign waiting = state == GET_ADDR || state == GET_DATA;
  assign expire = waiting && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign busy_phase = state == EXEC || state == SEND || state == WAIT_BUSY || state == WAIT_IDLE;
  assign we = state == EXEC && is_wr && addr_ok;
  uart_resp_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk(clk),
    .reset(reset),
    .we(we),
    .addr(addr[AW-1:0]),
    .wdata(data),
    .rdata(rdata),
    .regs_flat(regs_flat)
  );
  // command FSM; when the transmitter is already idle the start pulse is issued straight from IDLE/EXEC to meet latency
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tx_data <= '0;
      tx_start <= 1'b0;
      timeout_pulse <= 1'b0;
      rx_drop <= 1'b0;
      cnt <= '0;
      is_wr <= 1'b0;
      addr <= '0;
      data <= '0;
    end else begin
      tx_start <= 1'b0;
      timeout_pulse <= 1'b0;
      cnt <= (waiting && !rx_done && !expire) ? cnt + CW'(1) : '0;
      if (rx_done && busy_phase) rx_drop <= 1'b1;
      if (expire) begin
        state <= IDLE;
        timeout_pulse <= 1'b1;
      end else begin
        case (state)
          IDLE: if (rx_done) begin
            is_wr <= rx_data == CMD_WR;
            if (rx_data == CMD_WR || rx_data == CMD_RD) state <= GET_ADDR;
            else begin
              tx_data <= RSP_NAK;
              tx_start <= !tx_busy;
              state <= tx_busy ? SEND : WAIT_BUSY;
            end
          end
          GET_ADDR: if (rx_done) begin
            addr <= rx_data;
            state <= is_wr ? GET_DATA : EXEC;
          end
          GET_DATA: if (rx_done) begin
            data <= rx_data;
            state <= EXEC;
          end
          EXEC: begin
            tx_data <= !addr_ok ? RSP_NAK : is_wr ? RSP_ACK : rdata;
            tx_start <= !tx_busy;
            state <= tx_busy ? SEND : WAIT_BUSY;
          end
          SEND: if (!tx_busy) begin
            tx_start <= 1'b1;
            state <= WAIT_BUSY;
          end
          WAIT_BUSY: if (tx_busy) state <= WAIT_IDLE;
          WAIT_IDLE: if (!tx_busy) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_reg_responder.sv
// tb_uart_reg_responder: table-driven command vectors with a response scoreboard plus backpressure, timeout, drop and reset sequences
module tb_uart_reg_responder;
  localparam int NR = 8;
  localparam int TO = 16;
  logic clk = 1'b0, reset = 1'b1, rx_done = 1'b0, hold_busy = 1'b0;
  logic tx_start, tx_busy, timeout_pulse, rx_drop;
  logic [7:0] rx_data = 8'h00, tx_data;
  logic [NR*8-1:0] regs_flat;
  logic [7:0] mdl [NR];
  int n_cmp = 0, n_err = 0, cyc = 0, last_rx = 0, tx_cyc = 0, tx_count = 0, busy_cnt = 0;
  typedef struct { logic [7:0] d; int lat; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  typedef struct { int n; logic [7:0] b0, b1, b2, rsp; } vec_t;
  vec_t vecs [12];

  uart_reg_responder #(.NUM_REGS(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_busy(tx_busy),
    .regs_flat(regs_flat),
    .timeout_pulse(timeout_pulse),
    .rx_drop(rx_drop)
  );

  always #5 clk = ~clk;
  assign tx_busy = hold_busy || busy_cnt > 0;

  // transmitter model: busy for four cycles after each start request
  always @(posedge clk) begin
    cyc <= cyc + 1;
    busy_cnt <= tx_start ? 4 : (busy_cnt > 0 ? busy_cnt - 1 : 0);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // scoreboard: every transmitted byte is matched against the oldest expected response
  always @(negedge clk) if (tx_start) begin
    tx_count++;
    tx_cyc = cyc;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_tx: got %h expected no transmission", tx_data);
    end else begin
      mon_e = exp_q.pop_front();
      chk("tx_data", 64'(tx_data), 64'(mon_e.d));
      if (mon_e.lat >= 0) chk("latency", 64'(tx_cyc - last_rx), 64'(mon_e.lat));
    end
  end

  function automatic logic [NR*8-1:0] mdl_flat();
    logic [NR*8-1:0] f;
    for (int i = 0; i < NR; i++) f[8*i +: 8] = mdl[i];
    return f;
  endfunction

  task automatic push_exp(input logic [7:0] d, input int lat);
    exp_t e;
    e.d = d;
    e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    last_rx = cyc;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic wait_tx(input int target, input string nm);
    int k = 0;
    while (tx_count < target && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (tx_count < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got %0d transmissions expected %0d", nm, tx_count, target);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int want = tx_count + 1;
    push_exp(v.rsp, v.n == 1 ? 1 : 2);
    send_byte(v.b0);
    if (v.n > 1) send_byte(v.b1);
    if (v.n > 2) send_byte(v.b2);
    if (v.n == 3 && v.b0 == 8'h57 && v.b1 < NR) mdl[v.b1[2:0]] = v.b2;
    wait_tx(want, "vec_tx");
    chk("regs", 64'(regs_flat), 64'(mdl_flat()));
  endtask

  initial begin
    int want, first, pulses, drop;
    logic [7:0] td;
    logic stable;
    vec_t v;
    for (int i = 0; i < NR; i++) mdl[i] = 8'h00;
    vecs[0]  = '{3, 8'h57, 8'h03, 8'hA5, 8'h06};
    vecs[1]  = '{2, 8'h52, 8'h03, 8'h00, 8'hA5};
    vecs[2]  = '{1, 8'h41, 8'h00, 8'h00, 8'h15};
    vecs[3]  = '{3, 8'h57, 8'h08, 8'hFF, 8'h15};
    vecs[4]  = '{2, 8'h52, 8'hFF, 8'h00, 8'h15};
    vecs[5]  = '{3, 8'h57, 8'h00, 8'h11, 8'h06};
    vecs[6]  = '{3, 8'h57, 8'h07, 8'hEE, 8'h06};
    vecs[7]  = '{2, 8'h52, 8'h07, 8'h00, 8'hEE};
    vecs[8]  = '{2, 8'h52, 8'h00, 8'h00, 8'h11};
    vecs[9]  = '{3, 8'h57, 8'h05, 8'h5A, 8'h06};
    vecs[10] = '{2, 8'h52, 8'h05, 8'h00, 8'h5A};
    vecs[11] = '{1, 8'h00, 8'h00, 8'h00, 8'h15};
    repeat (3) @(negedge clk);
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_timeout", 64'(timeout_pulse), 64'd0);
    chk("rst_rx_drop", 64'(rx_drop), 64'd0);
    chk("rst_regs", 64'(regs_flat), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    want = tx_count + 1;
    hold_busy = 1'b1;
    push_exp(8'hA5, -1);
    send_byte(8'h52);
    send_byte(8'h03);
    repeat (3) @(negedge clk);
    td = tx_data;
    chk("bp_tx_data", 64'(td), 64'hA5);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_data !== td || tx_start !== 1'b0) stable = 1'b0;
    end
    chk("bp_held", 64'(stable), 64'd1);
    chk("bp_no_start", 64'(tx_count), 64'(want - 1));
    @(negedge clk);
    hold_busy = 1'b0;
    drop = cyc;
    wait_tx(want, "bp_tx");
    chk("bp_start_cycle", 64'(tx_cyc), 64'(drop + 1));
    chk("bp_once", 64'(tx_count), 64'(want));

    want = tx_count;
    send_byte(8'h57);
    send_byte(8'h02);
    first = -1;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (timeout_pulse) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    chk("to_pulses", 64'(pulses), 64'd1);
    chk("to_window", 64'(first >= 15 && first <= 16), 64'd1);
    chk("to_no_tx", 64'(tx_count), 64'(want));
    chk("to_regs", 64'(regs_flat), 64'(mdl_flat()));
    v = '{2, 8'h52, 8'h02, 8'h00, 8'h00};
    run_vec(v);

    want = tx_count + 1;
    push_exp(8'hA5, 2);
    send_byte(8'h52);
    send_byte(8'h03);
    for (int k = 0; k < 300 && tx_count < want; k++) @(negedge clk);
    chk("drop_tx_seen", 64'(tx_count), 64'(want));
    @(negedge clk);
    send_byte(8'h33);
    chk("drop_set", 64'(rx_drop), 64'd1);
    repeat (8) @(negedge clk);
    v = '{3, 8'h57, 8'h04, 8'h77, 8'h06};
    run_vec(v);
    chk("drop_sticky", 64'(rx_drop), 64'd1);

    send_byte(8'h57);
    send_byte(8'h01);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NR; i++) mdl[i] = 8'h00;
    chk("rgd_tx_start", 64'(tx_start), 64'd0);
    chk("rgd_tx_data", 64'(tx_data), 64'd0);
    chk("rgd_regs", 64'(regs_flat), 64'd0);
    chk("rgd_rx_drop", 64'(rx_drop), 64'd0);
    want = tx_count;
    repeat (20) @(negedge clk);
    chk("rgd_no_tx", 64'(tx_count), 64'(want));

    hold_busy = 1'b1;
    send_byte(8'h41);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hold_busy = 1'b0;
    chk("rsend_tx_start", 64'(tx_start), 64'd0);
    chk("rsend_tx_data", 64'(tx_data), 64'd0);
    repeat (20) @(negedge clk);
    chk("rsend_no_tx", 64'(tx_count), 64'(want));
    v = '{2, 8'h52, 8'h03, 8'h00, 8'h00};
    run_vec(v);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
